// File: rtl/awawawawa_pkg.sv
// awawawawa_pkg
// Shared constants for the LVDC I/O-controller CPLD: the CPU port address
// map, status-register bit positions, SPI frame length, the display
// multiplex divider width and the hex-to-7-segment decode.
package awawawawa_pkg;

    localparam logic [3:0] ADDR_GPIO      = 4'd0;
    localparam logic [3:0] ADDR_BODGE0    = 4'd1;
    localparam logic [3:0] ADDR_BODGE1    = 4'd2;
    localparam logic [3:0] ADDR_SPI_FLASH = 4'd3;
    localparam logic [3:0] ADDR_SPI_LED   = 4'd4;
    localparam logic [3:0] ADDR_STATUS    = 4'd5;
    localparam logic [3:0] ADDR_RADAR     = 4'd6;
    localparam logic [3:0] ADDR_DISPLAY   = 4'd7;
    localparam logic [3:0] ADDR_SID       = 4'd8;

    localparam int STAT_PENDING = 0;
    localparam int STAT_KEY     = 1;
    localparam int STAT_RPULSE  = 2;
    localparam int STAT_RD0     = 3;
    localparam int STAT_RD1     = 4;
    localparam int STAT_RCHECK  = 5;
    localparam int STAT_TEMP    = 6;

    localparam int SPI_BITS     = 8;
    localparam int SPI_BUSY_BIT = 15;
    localparam int MUX_DIV_W    = 10;

    typedef enum logic {
        SPI_SEL_FLASH = 1'b0,
        SPI_SEL_LED   = 1'b1
    } spi_sel_e;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/awa_spi_byte.sv
// awa_spi_byte
// Byte-wide SPI mode-0 shift engine, MSB first, two system clocks per bit.
// Ports:
//   clk, rst        system clock, async active-high reset
//   start_i         one-cycle request; ignored while busy_o
//   tx_i            byte to send, sampled with start_i
//   sdi_i           serial data in, sampled as sck_o rises
//   busy_o          high for the 16 clocks of a transfer
//   sck_o, sdo_o    serial clock and data out
//   rx_o            last fully received byte, updated as busy_o drops
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for start_i, sck low
// ST_LOW  | sck low half-bit, sdo holds current bit
// ST_HIGH | sck high half-bit, sdi already sampled
module awa_spi_byte
    import awawawawa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] tx_i,
    input  logic       sdi_i,
    output logic       busy_o,
    output logic       sck_o,
    output logic       sdo_o,
    output logic [7:0] rx_o
);

    localparam int CNT_W = $clog2(SPI_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_e;

    state_e           state_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_sh_q;
    logic [CNT_W-1:0] bits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
            sck_o   <= 1'b0;
            sdo_o   <= 1'b0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_o    <= '0;
            bits_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LOW;
                        busy_o  <= 1'b1;
                        sdo_o   <= tx_i[7];
                        tx_q    <= {tx_i[6:0], 1'b0};
                        bits_q  <= CNT_W'(SPI_BITS - 1);
                    end
                end
                ST_LOW: begin
                    sck_o   <= 1'b1;
                    rx_sh_q <= {rx_sh_q[6:0], sdi_i};
                    state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    sck_o <= 1'b0;
                    if (bits_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                        rx_o    <= rx_sh_q;
                    end else begin
                        sdo_o   <= tx_q[7];
                        tx_q    <= {tx_q[6:0], 1'b0};
                        bits_q  <= bits_q - 1'b1;
                        state_q <= ST_LOW;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/awawawawa_cpld.sv
// awawawawa_cpld
// LVDC I/O-controller CPLD: CPU I/O strobe decode, GPIO latch/buffer
// enables, SPI master (boot flash / LED driver), key interrupt, radar
// adapter register and an optional two-display 7-segment driver.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   IORb, IOWb, I            CPU read/write strobes (active low), port address
//   bus                      CPLD side of the data transceiver
//   BDIR                     1 while the CPLD sources read data
//   GPIO_LOAD, GPIO_READb    external latch clock / input buffer enable
//   BODGE0, BODGE1, SID_CEb  further active-low enables
//   INT_INHIBIT, KEY_CLEARb  interrupt mask, operator key
//   INTERRUPT, LED           interrupt request, activity lamp
//   TEMP, RPULSE, RD0, RD1, RCHECK   status inputs
//   RPULSE_OUT, RD0_OUT, RD1_OUT     radar-adapter outputs
//   SDO, SDI, SCK_FLASH, SCK_LED1    SPI pins
//   SSEL_R1, R1_SEGS, R2_SEGS        7-segment display drive
// Build option: define AWA_DISPLAY_EN to include the display register
// (address 7), segment decode and multiplex counter.
module awawawawa_cpld
    import awawawawa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        IORb,
    input  logic        IOWb,
    input  logic [3:0]  I,
    inout  wire  [15:0] bus,
    output logic        BDIR,
    output logic        GPIO_LOAD,
    output logic        GPIO_READb,
    output logic        BODGE0,
    output logic        BODGE1,
    input  logic        INT_INHIBIT,
    input  logic        KEY_CLEARb,
    output logic        INTERRUPT,
    input  logic        TEMP,
    input  logic        RPULSE,
    input  logic        RD0,
    input  logic        RD1,
    input  logic        RCHECK,
    output logic        RPULSE_OUT,
    output logic        RD0_OUT,
    output logic        RD1_OUT,
    output logic        SDO,
    input  logic        SDI,
    output logic        SCK_FLASH,
    output logic        SCK_LED1,
    output logic        SID_CEb,
    output logic        LED,
    output logic        SSEL_R1,
    output logic [6:0]  R1_SEGS,
    output logic [6:0]  R2_SEGS
);

    // Synchronizer stages reset to 1 (the idle level of these active-low
    // inputs) so leaving reset never looks like a strobe or key edge.
    logic iorb_s1_q, iorb_s2_q, iorb_s3_q;
    logic iowb_s1_q, iowb_s2_q, iowb_s3_q;
    logic key_s1_q, key_s2_q, key_s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {iorb_s1_q, iorb_s2_q, iorb_s3_q} <= 3'b111;
            {iowb_s1_q, iowb_s2_q, iowb_s3_q} <= 3'b111;
            {key_s1_q, key_s2_q, key_s3_q}    <= 3'b111;
        end else begin
            {iorb_s1_q, iorb_s2_q, iorb_s3_q} <= {IORb, iorb_s1_q, iorb_s2_q};
            {iowb_s1_q, iowb_s2_q, iowb_s3_q} <= {IOWb, iowb_s1_q, iowb_s2_q};
            {key_s1_q, key_s2_q, key_s3_q}    <= {KEY_CLEARb, key_s1_q, key_s2_q};
        end
    end

    logic rd_done, wr_done, key_fall;
    assign rd_done  = iorb_s2_q & ~iorb_s3_q;
    assign wr_done  = iowb_s2_q & ~iowb_s3_q;
    assign key_fall = ~key_s2_q & key_s3_q;

    logic [3:0]  waddr_q, raddr_q;
    logic [15:0] wdata_q;
    logic        gpio_load_q;
    logic        pending_q;
    logic [2:0]  radar_q;
    spi_sel_e    spi_sel_q;

    logic       spi_start, spi_busy, spi_sck;
    logic [7:0] spi_rx;

    assign spi_start = wr_done & ~spi_busy &
                       ((waddr_q == ADDR_SPI_FLASH) || (waddr_q == ADDR_SPI_LED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            gpio_load_q <= 1'b0;
            pending_q   <= 1'b0;
            radar_q     <= '0;
            spi_sel_q   <= SPI_SEL_FLASH;
        end else begin
            if (!iowb_s2_q) begin
                waddr_q <= I;
                wdata_q <= bus;
            end
            if (!iorb_s2_q) begin
                raddr_q <= I;
            end
            // iowb_s3_q low marks the second synchronized-low clock, by
            // which time waddr_q holds this write's address.
            if (iowb_s2_q) begin
                gpio_load_q <= 1'b0;
            end else if (!iowb_s3_q && waddr_q == ADDR_GPIO) begin
                gpio_load_q <= 1'b1;
            end
            if (key_fall) begin
                pending_q <= 1'b1;
            end else if (rd_done && raddr_q == ADDR_STATUS) begin
                pending_q <= 1'b0;
            end
            if (wr_done && waddr_q == ADDR_RADAR) begin
                radar_q <= wdata_q[2:0];
            end
            if (spi_start) begin
                spi_sel_q <= (waddr_q == ADDR_SPI_LED) ? SPI_SEL_LED : SPI_SEL_FLASH;
            end
        end
    end

    awa_spi_byte u_spi (
        .clk     (clk),
        .rst     (rst),
        .start_i (spi_start),
        .tx_i    (wdata_q[7:0]),
        .sdi_i   (SDI),
        .busy_o  (spi_busy),
        .sck_o   (spi_sck),
        .sdo_o   (SDO),
        .rx_o    (spi_rx)
    );

    assign SCK_FLASH = spi_sck & (spi_sel_q == SPI_SEL_FLASH);
    assign SCK_LED1  = spi_sck & (spi_sel_q == SPI_SEL_LED);

    logic [15:0] disp_rd;

`ifdef AWA_DISPLAY_EN
    logic [11:0]          disp_q;
    logic [MUX_DIV_W-1:0] mux_cnt_q;
    logic                 ssel_q;
    logic                 unused_wdata;

    // Down-counter starting at all-ones gives the same 1024-clock period
    // as a free-running up-counter that toggles on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q    <= '0;
            mux_cnt_q <= '1;
            ssel_q    <= 1'b0;
        end else begin
            if (wr_done && waddr_q == ADDR_DISPLAY) begin
                disp_q <= wdata_q[11:0];
            end
            if (mux_cnt_q == '0) begin
                mux_cnt_q <= '1;
                ssel_q    <= ~ssel_q;
            end else begin
                mux_cnt_q <= mux_cnt_q - 1'b1;
            end
        end
    end

    assign SSEL_R1      = ssel_q;
    assign R1_SEGS      = hex_to_seg(ssel_q ? disp_q[11:8] : disp_q[7:4]);
    assign R2_SEGS      = hex_to_seg(disp_q[3:0]);
    assign disp_rd      = {4'b0, disp_q};
    assign unused_wdata = ^wdata_q[15:12];
`else
    logic unused_wdata;

    assign SSEL_R1      = 1'b0;
    assign R1_SEGS      = '0;
    assign R2_SEGS      = '0;
    assign disp_rd      = '0;
    assign unused_wdata = ^wdata_q[15:8];
`endif

    logic [15:0] status;
    logic [15:0] rdata;
    logic        rd_drive;

    always_comb begin
        status               = '0;
        status[STAT_PENDING] = pending_q;
        status[STAT_KEY]     = ~KEY_CLEARb;
        status[STAT_RPULSE]  = RPULSE;
        status[STAT_RD0]     = RD0;
        status[STAT_RD1]     = RD1;
        status[STAT_RCHECK]  = RCHECK;
        status[STAT_TEMP]    = TEMP;
    end

    always_comb begin
        rdata = '0;
        case (I)
            ADDR_SPI_FLASH,
            ADDR_SPI_LED: begin
                rdata[7:0]          = spi_rx;
                rdata[SPI_BUSY_BIT] = spi_busy;
            end
            ADDR_STATUS:  rdata = status;
            ADDR_RADAR:   rdata = {13'b0, radar_q};
            ADDR_DISPLAY: rdata = disp_rd;
            default:      rdata = '0;
        endcase
    end

    // GPIO, BODGE and SID reads are sourced by external parts, so the
    // transceiver must keep pointing away from the CPU for those.
    assign rd_drive = ~IORb & (((I >= ADDR_SPI_FLASH) && (I <= ADDR_DISPLAY)) || (I > ADDR_SID));
    assign BDIR     = rd_drive;
    assign bus      = rd_drive ? rdata : 16'hzzzz;

    assign GPIO_READb = ~(~IORb & (I == ADDR_GPIO));
    assign BODGE0     = ~(~IORb & (I == ADDR_BODGE0));
    assign BODGE1     = ~(~IORb & (I == ADDR_BODGE1));
    assign SID_CEb    = ~((~IORb | ~IOWb) & (I == ADDR_SID));

    assign GPIO_LOAD  = gpio_load_q;
    assign INTERRUPT  = pending_q & ~INT_INHIBIT;
    assign LED        = spi_busy | pending_q;
    assign RPULSE_OUT = radar_q[0];
    assign RD0_OUT    = radar_q[1];
    assign RD1_OUT    = radar_q[2];

endmodule

// File: tb/tb_awawawawa_cpld.sv
module tb_awawawawa_cpld;

    logic        clk = 1'b0;
    logic        rst;
    logic        IORb, IOWb;
    logic [3:0]  I;
    wire  [15:0] bus;
    logic [15:0] bus_drv;
    logic        bus_en;
    logic        BDIR, GPIO_LOAD, GPIO_READb, BODGE0, BODGE1;
    logic        INT_INHIBIT, KEY_CLEARb, INTERRUPT;
    logic        TEMP, RPULSE, RD0, RD1, RCHECK;
    logic        RPULSE_OUT, RD0_OUT, RD1_OUT;
    logic        SDO, SDI, SCK_FLASH, SCK_LED1, SID_CEb, LED, SSEL_R1;
    logic [6:0]  R1_SEGS, R2_SEGS;

    assign bus = bus_en ? bus_drv : 16'hzzzz;

    awawawawa_cpld dut (
        .clk(clk), .rst(rst), .IORb(IORb), .IOWb(IOWb), .I(I), .bus(bus),
        .BDIR(BDIR), .GPIO_LOAD(GPIO_LOAD), .GPIO_READb(GPIO_READb),
        .BODGE0(BODGE0), .BODGE1(BODGE1), .INT_INHIBIT(INT_INHIBIT),
        .KEY_CLEARb(KEY_CLEARb), .INTERRUPT(INTERRUPT), .TEMP(TEMP),
        .RPULSE(RPULSE), .RD0(RD0), .RD1(RD1), .RCHECK(RCHECK),
        .RPULSE_OUT(RPULSE_OUT), .RD0_OUT(RD0_OUT), .RD1_OUT(RD1_OUT),
        .SDO(SDO), .SDI(SDI), .SCK_FLASH(SCK_FLASH), .SCK_LED1(SCK_LED1),
        .SID_CEb(SID_CEb), .LED(LED), .SSEL_R1(SSEL_R1),
        .R1_SEGS(R1_SEGS), .R2_SEGS(R2_SEGS)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // SPI slave model: shifts out slave_byte MSB first, next bit presented
    // after each SCK rise; records the SDO bit seen at each rise.
    int         flash_pulses = 0;
    int         led_pulses = 0;
    logic [7:0] sdo_seq = 8'h00;
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] bit_idx;
    assign bit_idx = 3'(flash_pulses + led_pulses);
    assign SDI     = slave_byte[3'd7 - bit_idx];

    always @(posedge SCK_FLASH or posedge SCK_LED1) begin
        if (SCK_FLASH) flash_pulses = flash_pulses + 1;
        else           led_pulses   = led_pulses + 1;
        sdo_seq = {sdo_seq[6:0], SDO};
    end

    int   gl_cnt = 0;
    logic gl_iowb = 1'b1;
    always @(posedge GPIO_LOAD) begin
        gl_cnt  = gl_cnt + 1;
        gl_iowb = IOWb;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        I = a; bus_drv = d; bus_en = 1'b1; IOWb = 1'b0;
        repeat (2) @(negedge clk);
        check("wr_bdir", 16'(BDIR), 16'd0);
        repeat (3) @(negedge clk);
        IOWb = 1'b1;
        repeat (3) @(negedge clk);
        bus_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] d, output logic bd);
        @(negedge clk);
        bus_en = 1'b0; I = a; IORb = 1'b0;
        @(negedge clk);
        d  = bus;
        bd = BDIR;
        repeat (3) @(negedge clk);
        IORb = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [15:0] rd;
    logic        bd;
    logic        seen;
    int          fp0;
    int          gap;
    logic        s0;

    initial begin
        rst = 1'b1; IORb = 1'b1; IOWb = 1'b1; I = 4'd0;
        bus_drv = 16'h0000; bus_en = 1'b0;
        INT_INHIBIT = 1'b0; KEY_CLEARb = 1'b1;
        TEMP = 1'b1; RPULSE = 1'b0; RD0 = 1'b1; RD1 = 1'b0; RCHECK = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_bdir",      16'(BDIR),       16'd0);
        check("rst_interrupt", 16'(INTERRUPT),  16'd0);
        check("rst_gpio_readb",16'(GPIO_READb), 16'd1);
        check("rst_sid_ceb",   16'(SID_CEb),    16'd1);
        check("rst_gpio_load", 16'(GPIO_LOAD),  16'd0);
        check("rst_led",       16'(LED),        16'd0);
        check("rst_scks",      16'({SCK_FLASH, SCK_LED1, SDO}), 16'd0);
`ifdef AWA_DISPLAY_EN
        check("rst_segs", {2'b0, R1_SEGS, R2_SEGS}, {2'b0, 7'h3F, 7'h3F});
`else
        check("rst_segs", {2'b0, R1_SEGS, R2_SEGS}, 16'd0);
`endif
        check("rst_ssel", 16'(SSEL_R1), 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // GPIO write and read
        do_write(4'd0, 16'h00A5);
        check("gpio_load_pulses", 16'(gl_cnt),    16'd1);
        check("gpio_load_in_low", 16'(gl_iowb),   16'd0);
        check("gpio_load_after",  16'(GPIO_LOAD), 16'd0);
        @(negedge clk);
        I = 4'd0; IORb = 1'b0;
        #1;
        check("gpio_readb_low", 16'(GPIO_READb), 16'd0);
        check("gpio_rd_bdir",   16'(BDIR),       16'd0);
        @(negedge clk);
        IORb = 1'b1;
        #1;
        check("gpio_readb_high", 16'(GPIO_READb), 16'd1);

        // Flash SPI transfer; second write while busy must be ignored
        slave_byte = 8'hEF;
        fp0 = flash_pulses;
        do_write(4'd3, 16'h009F);
        check("spi_busy_led", 16'(LED), 16'd1);
        do_write(4'd3, 16'h0055);
        repeat (25) @(negedge clk);
        check("flash_pulses", 16'(flash_pulses - fp0), 16'd8);
        check("flash_sdo",    16'(sdo_seq),            16'h009F);
        check("led_idle",     16'(led_pulses),         16'd0);
        do_read(4'd3, rd, bd);
        check("flash_rx",   rd,       16'h00EF);
        check("flash_bdir", 16'(bd),  16'd1);

        // LED SPI transfer
        slave_byte = 8'h5A;
        do_write(4'd4, 16'h003C);
        repeat (20) @(negedge clk);
        check("led_pulses",   16'(led_pulses),            16'd8);
        check("led_no_flash", 16'(flash_pulses - fp0),    16'd8);
        check("led_sdo",      16'(sdo_seq),               16'h003C);
        do_read(4'd4, rd, bd);
        check("led_rx", rd, 16'h005A);

        // Interrupt, unmasked
        @(negedge clk);
        KEY_CLEARb = 1'b0;
        repeat (2) @(negedge clk);
        check("int_early", 16'(INTERRUPT), 16'd0);
        @(negedge clk);
        check("int_set", 16'(INTERRUPT), 16'd1);
        KEY_CLEARb = 1'b1;
        repeat (3) @(negedge clk);
        do_read(4'd5, rd, bd);
        check("status_pending", rd, 16'h0069);
        check("int_cleared", 16'(INTERRUPT), 16'd0);

        // Interrupt, masked
        INT_INHIBIT = 1'b1;
        @(negedge clk);
        KEY_CLEARb = 1'b0;
        repeat (4) @(negedge clk);
        check("int_masked",   16'(INTERRUPT), 16'd0);
        check("pending_lamp", 16'(LED),       16'd1);
        do_read(4'd5, rd, bd);
        check("status_masked", rd, 16'h006B);
        check("lamp_cleared", 16'(LED), 16'd0);
        KEY_CLEARb = 1'b1;
        INT_INHIBIT = 1'b0;
        repeat (3) @(negedge clk);

        // Radar register
        do_write(4'd6, 16'h0005);
        check("radar_out", 16'({RD1_OUT, RD0_OUT, RPULSE_OUT}), 16'd5);
        do_read(4'd6, rd, bd);
        check("radar_rd",   rd,      16'h0005);
        check("radar_bdir", 16'(bd), 16'd1);

        // Other decodes
        do_read(4'd9, rd, bd);
        check("addr9_rd",   rd,      16'h0000);
        check("addr9_bdir", 16'(bd), 16'd1);
        @(negedge clk);
        I = 4'd1; IORb = 1'b0;
        #1;
        check("bodge0", 16'({BODGE0, BODGE1, BDIR}), 16'b010);
        @(negedge clk);
        IORb = 1'b1; I = 4'd8; IOWb = 1'b0;
        #1;
        check("sid_ce_wr", 16'({SID_CEb, BDIR}), 16'b00);
        @(negedge clk);
        IOWb = 1'b1;
        #1;
        check("sid_ce_idle", 16'(SID_CEb), 16'd1);
        repeat (4) @(negedge clk);

        // Display
        do_write(4'd7, 16'h0218);
`ifdef AWA_DISPLAY_EN
        check("r2_segs", 16'(R2_SEGS), 16'h007F);
        do_read(4'd7, rd, bd);
        check("disp_rd", rd, 16'h0218);
        s0 = SSEL_R1;
        seen = 1'b0;
        for (int k = 0; k < 1100 && !seen; k++) begin
            @(negedge clk);
            if (SSEL_R1 != s0) seen = 1'b1;
        end
        if (!seen) check("ssel_timeout", 16'(seen), 16'd1);
        check("r1_segs_a", 16'(R1_SEGS), SSEL_R1 ? 16'h005B : 16'h0006);
        s0 = SSEL_R1;
        seen = 1'b0;
        gap = 0;
        for (int k = 0; k < 1100 && !seen; k++) begin
            @(negedge clk);
            gap = gap + 1;
            if (SSEL_R1 != s0) seen = 1'b1;
        end
        check("ssel_period", 16'(gap), 16'd1024);
        check("r1_segs_b", 16'(R1_SEGS), SSEL_R1 ? 16'h005B : 16'h0006);
`else
        check("segs_off", {1'b0, SSEL_R1, R1_SEGS, R2_SEGS}, 16'd0);
        do_read(4'd7, rd, bd);
        check("disp_rd_off", rd, 16'h0000);
`endif

        // Reset in the middle of a transfer
        slave_byte = 8'h00;
        do_write(4'd4, 16'h00FF);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (SCK_LED1) seen = 1'b1;
        end
        check("sck_seen", 16'(seen), 16'd1);
        rst = 1'b1;
        #1;
        check("rst_abort_sck", 16'({SCK_LED1, SCK_FLASH}), 16'd0);
        check("rst_abort_led", 16'(LED), 16'd0);
        check("rst_radar", 16'({RD1_OUT, RD0_OUT, RPULSE_OUT}), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
